// File: rtl/tjmono2_rx_stream_filter.sv
// tjmono2_rx_stream_filter
//   Sits behind the TJ-Monopix2 RX core's 32-bit output FIFO (same clock as
//   the bus). It pops words with the FIFO's one-cycle read latency and can
//   drop words that match a pattern/mask. It can stop after a programmable
//   number of reads. Surviving words go out on a valid/ready stream through
//   a 2-entry skid buffer.
//
// Ports
//   BUS_CLK, RST         clock, synchronous active-high reset
//   BUS_ADD/DATA_IN/WR/RD basil-style 8-bit register bus
//   BUS_DATA_OUT         registered read data (only updated on BUS_RD)
//   RX_FIFO_EMPTY/READ   RX FIFO handshake; data is valid the cycle after READ
//   RX_FIFO_DATA         {identifier[3:0], FE_DATA[27:0]}
//   OUT_DATA/VALID/READY forwarded word stream
//   LIMIT_REACHED        READ_CNT has reached LIMIT while LIMIT_EN is set
//
// Register map
//   0 VERSION (R) / soft reset (W)    1 CTRL {CLR_CNT,4'b0,LIMIT_EN,FILTER_EN,EN}
//   2-5 PATTERN[27:0]   6-9 MASK[27:0]   10-13 LIMIT[31:0]
//   14-17 READ_CNT  18-21 FWD_CNT  22-23 DROP_CNT (low byte read latches all)
module tjmono2_rx_stream_filter #(
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned VERSION   = 1
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic                 RX_FIFO_EMPTY,
  output logic                 RX_FIFO_READ,
  input  logic [31:0]          RX_FIFO_DATA,
  output logic [31:0]          OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 LIMIT_REACHED
);
  localparam logic [7:0] VERSION_B = 8'(VERSION);

  logic             en_q, en_d, filter_en_q, filter_en_d, limit_en_q, limit_en_d;
  logic [27:0]      pattern_q, pattern_d, mask_q, mask_d;
  logic [31:0]      limit_q, limit_d;
  logic [31:0]      read_cnt_q, read_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [31:0]      read_lat_q, read_lat_d, fwd_lat_q, fwd_lat_d;
  logic [15:0]      drop_lat_q, drop_lat_d;
  logic [1:0][31:0] mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [7:0]       bus_data_out_q, bus_data_out_d;

  logic       irst, reg_hit, pop, rd_room, filt_hit, drop, push, clr_cnt;
  logic [4:0] reg_sel;
  logic [1:0] occ_eff;

  // Writing address 0 is a soft reset with the same reach as RST.
  assign irst    = RST | (BUS_WR & (BUS_ADD == '0));
  assign reg_hit = BUS_ADD < ABUSWIDTH'(24);
  assign reg_sel = BUS_ADD[4:0];

  assign OUT_VALID     = (occ_q != 2'd0);
  assign OUT_DATA      = mem_q[rd_ptr_q];
  assign LIMIT_REACHED = limit_en_q & (read_cnt_q >= limit_q);
  assign BUS_DATA_OUT  = bus_data_out_q;

  // Buffer slots still free after this cycle's pop. The in-flight word and
  // the word we are about to request must both fit, so the buffer can never
  // overflow. This still allows one read per cycle in steady state.
  assign pop     = OUT_VALID & OUT_READY;
  assign occ_eff = occ_q - {1'b0, pop};
  assign rd_room = ({1'b0, occ_eff} + {2'b0, inflight_q}) < 3'd2;
  assign RX_FIFO_READ = en_q & ~RX_FIFO_EMPTY & ~LIMIT_REACHED & rd_room & ~irst;

  // The word returning from last cycle's read is either dropped or buffered.
  // With MASK=0 every word matches, so FILTER_EN then drops everything.
  assign filt_hit = (((RX_FIFO_DATA[27:0] ^ pattern_q) & mask_q) == 28'd0);
  assign drop     = inflight_q & filter_en_q & filt_hit;
  assign push     = inflight_q & ~(filter_en_q & filt_hit);
  assign clr_cnt  = BUS_WR & reg_hit & (reg_sel == 5'd1) & BUS_DATA_IN[7];

  always_comb begin
    en_d           = en_q;
    filter_en_d    = filter_en_q;
    limit_en_d     = limit_en_q;
    pattern_d      = pattern_q;
    mask_d         = mask_q;
    limit_d        = limit_q;
    read_lat_d     = read_lat_q;
    fwd_lat_d      = fwd_lat_q;
    drop_lat_d     = drop_lat_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    bus_data_out_d = bus_data_out_q;
    inflight_d     = RX_FIFO_READ;

    // skid buffer
    if (push) begin
      mem_d[wr_ptr_q] = RX_FIFO_DATA;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    // counters; a clear wins over a coincident increment
    read_cnt_d = read_cnt_q + {31'd0, RX_FIFO_READ};
    fwd_cnt_d  = fwd_cnt_q + {31'd0, pop};
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (clr_cnt) begin
      read_cnt_d = '0;
      fwd_cnt_d  = '0;
      drop_cnt_d = '0;
    end

    // register writes (bits [31:28] of PATTERN/MASK do not exist)
    if (BUS_WR && reg_hit) begin
      case (reg_sel)
        5'd1: begin
          en_d        = BUS_DATA_IN[0];
          filter_en_d = BUS_DATA_IN[1];
          limit_en_d  = BUS_DATA_IN[2];
        end
        5'd2:  pattern_d[7:0]   = BUS_DATA_IN;
        5'd3:  pattern_d[15:8]  = BUS_DATA_IN;
        5'd4:  pattern_d[23:16] = BUS_DATA_IN;
        5'd5:  pattern_d[27:24] = BUS_DATA_IN[3:0];
        5'd6:  mask_d[7:0]      = BUS_DATA_IN;
        5'd7:  mask_d[15:8]     = BUS_DATA_IN;
        5'd8:  mask_d[23:16]    = BUS_DATA_IN;
        5'd9:  mask_d[27:24]    = BUS_DATA_IN[3:0];
        5'd10: limit_d[7:0]     = BUS_DATA_IN;
        5'd11: limit_d[15:8]    = BUS_DATA_IN;
        5'd12: limit_d[23:16]   = BUS_DATA_IN;
        5'd13: limit_d[31:24]   = BUS_DATA_IN;
        default: ;
      endcase
    end

    // Register reads. The low-byte read of a counter snapshots the whole
    // counter, so the higher bytes read afterwards belong to the same value.
    if (BUS_RD) begin
      bus_data_out_d = 8'h00;
      if (reg_hit) begin
        case (reg_sel)
          5'd0:  bus_data_out_d = VERSION_B;
          5'd1:  bus_data_out_d = {5'd0, limit_en_q, filter_en_q, en_q};
          5'd2:  bus_data_out_d = pattern_q[7:0];
          5'd3:  bus_data_out_d = pattern_q[15:8];
          5'd4:  bus_data_out_d = pattern_q[23:16];
          5'd5:  bus_data_out_d = {4'd0, pattern_q[27:24]};
          5'd6:  bus_data_out_d = mask_q[7:0];
          5'd7:  bus_data_out_d = mask_q[15:8];
          5'd8:  bus_data_out_d = mask_q[23:16];
          5'd9:  bus_data_out_d = {4'd0, mask_q[27:24]};
          5'd10: bus_data_out_d = limit_q[7:0];
          5'd11: bus_data_out_d = limit_q[15:8];
          5'd12: bus_data_out_d = limit_q[23:16];
          5'd13: bus_data_out_d = limit_q[31:24];
          5'd14: begin
            bus_data_out_d = read_cnt_q[7:0];
            read_lat_d     = read_cnt_q;
          end
          5'd15: bus_data_out_d = read_lat_q[15:8];
          5'd16: bus_data_out_d = read_lat_q[23:16];
          5'd17: bus_data_out_d = read_lat_q[31:24];
          5'd18: begin
            bus_data_out_d = fwd_cnt_q[7:0];
            fwd_lat_d      = fwd_cnt_q;
          end
          5'd19: bus_data_out_d = fwd_lat_q[15:8];
          5'd20: bus_data_out_d = fwd_lat_q[23:16];
          5'd21: bus_data_out_d = fwd_lat_q[31:24];
          5'd22: begin
            bus_data_out_d = drop_cnt_q[7:0];
            drop_lat_d     = drop_cnt_q;
          end
          5'd23: bus_data_out_d = drop_lat_q[15:8];
          default: bus_data_out_d = 8'h00;
        endcase
      end
    end

    // Reset clears everything except the bus read register. Clearing
    // inflight and the buffer discards a word returning from a read issued
    // just before the reset.
    if (irst) begin
      en_d        = 1'b0;
      filter_en_d = 1'b0;
      limit_en_d  = 1'b0;
      pattern_d   = '0;
      mask_d      = '0;
      limit_d     = '0;
      read_cnt_d  = '0;
      fwd_cnt_d   = '0;
      drop_cnt_d  = '0;
      read_lat_d  = '0;
      fwd_lat_d   = '0;
      drop_lat_d  = '0;
      mem_d       = '0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      occ_d       = '0;
      inflight_d  = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    en_q           <= en_d;
    filter_en_q    <= filter_en_d;
    limit_en_q     <= limit_en_d;
    pattern_q      <= pattern_d;
    mask_q         <= mask_d;
    limit_q        <= limit_d;
    read_cnt_q     <= read_cnt_d;
    fwd_cnt_q      <= fwd_cnt_d;
    drop_cnt_q     <= drop_cnt_d;
    read_lat_q     <= read_lat_d;
    fwd_lat_q      <= fwd_lat_d;
    drop_lat_q     <= drop_lat_d;
    mem_q          <= mem_d;
    wr_ptr_q       <= wr_ptr_d;
    rd_ptr_q       <= rd_ptr_d;
    occ_q          <= occ_d;
    inflight_q     <= inflight_d;
    bus_data_out_q <= bus_data_out_d;
  end

endmodule
